// File: rtl/mem_pkg.sv
// Shared definitions for the two-port RAM arbiter: RAM command codes and FSM states.
package mem_pkg;

  localparam logic [1:0] MEM_RD  = 2'b00;
  localparam logic [1:0] MEM_WR  = 2'b01;
  localparam logic [1:0] MEM_NOP = 2'b10;

  // The RAM decodes this word address as the console output register.
  localparam logic [7:0] CONSOLE_ADDR = 8'hff;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin selector: on a tie the port that did not win last time is picked.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) grant_id = ~last_grant;
    else              grant_id = req1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported RAM between the core (port 0) and loader (port 1).
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic [1:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_bytes,
  input  logic [DATA_W-1:0] mem_data
);

  arb_state_t r_state, w_next;
  logic r_last_grant, r_owner;
  logic r_ack0, r_ack1, r_err0, r_err1;
  logic [DATA_W-1:0] r_rdata0, r_rdata1;
  logic [1:0] r_mem_op;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wb;

  logic w_gvalid, w_gid, w_sel_wr, w_oor;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata, w_resp_data;

  rr_pick2 u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (r_last_grant),
    .grant_valid (w_gvalid),
    .grant_id    (w_gid)
  );

  assign w_sel_wr    = w_gid ? wr1    : wr0;
  assign w_sel_addr  = w_gid ? addr1  : addr0;
  assign w_sel_wdata = w_gid ? wdata1 : wdata0;
  // Full-width compare: high address bits must never alias into the RAM.
  assign w_oor       = w_sel_addr >= ADDR_W'(MEM_WORDS);
  assign w_resp_data = (r_mem_op == MEM_WR) ? '0 : mem_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_gvalid) w_next = w_oor ? RESP : ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_mem_op     <= MEM_NOP;
      r_mem_addr   <= '0;
      r_mem_wb     <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_gvalid) begin
          r_owner      <= w_gid;
          r_last_grant <= w_gid;
          if (w_oor) begin
            if (w_gid) begin r_ack1 <= 1'b1; r_err1 <= 1'b1; r_rdata1 <= '0; end
            else       begin r_ack0 <= 1'b1; r_err0 <= 1'b1; r_rdata0 <= '0; end
          end else begin
            r_mem_op   <= w_sel_wr ? MEM_WR : MEM_RD;
            r_mem_addr <= w_sel_addr;
            r_mem_wb   <= w_sel_wdata;
          end
        end
        ACCESS: begin
          r_mem_op <= MEM_NOP;
          if (r_owner) begin r_ack1 <= 1'b1; r_err1 <= 1'b0; r_rdata1 <= w_resp_data; end
          else         begin r_ack0 <= 1'b1; r_err0 <= 1'b0; r_rdata0 <= w_resp_data; end
        end
        RESP: begin
          r_ack0 <= 1'b0;
          r_ack1 <= 1'b0;
          r_err0 <= 1'b0;
          r_err1 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ack0            = r_ack0;
  assign ack1            = r_ack1;
  assign err0            = r_err0;
  assign err1            = r_err1;
  assign rdata0          = r_rdata0;
  assign rdata1          = r_rdata1;
  assign mem_op          = r_mem_op;
  assign mem_addr        = r_mem_addr;
  assign mem_write_bytes = r_mem_wb;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: negedge RAM model, transaction-level reference model, directed + random traffic.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, wr0, wr1;
  logic [63:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [63:0] rdata0, rdata1;
  logic [1:0]  mem_op;
  logic [63:0] mem_addr, mem_wb;
  logic [63:0] mem_data = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_WORDS(256)) dut (
    .clk(clk), .reset(rst_n),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_write_bytes(mem_wb),
    .mem_data(mem_data)
  );

  // RAM executes the registered command on the falling edge.
  logic [63:0] ram [256];
  always @(negedge clk) begin
    if (mem_op == 2'b00) mem_data <= ram[mem_addr[7:0]];
    else if (mem_op == 2'b01) begin
      ram[mem_addr[7:0]] <= mem_wb;
      if (mem_addr == 64'hff) $display("console %02h", mem_wb[7:0]);
    end
  end

  // Reference model: transaction-level view (who wins, when the ack lands, what data it carries).
  logic [63:0] ref_mem [256];
  int          e = 0, m_free = 0, s_e = -1;
  bit          s_p, m_last;
  logic [63:0] s_rd;
  bit   [1:0]  x_ack, x_err;
  logic [63:0] x_rd [2];
  logic [1:0]  x_op;
  logic [63:0] x_addr, x_wb;

  int n_cmp = 0, n_bad = 0;
  bit rand_on = 0;
  bit ack_seen0 = 0, ack_seen1 = 0;

  task automatic m_reset();
    x_ack = '0; x_err = '0; x_rd[0] = '0; x_rd[1] = '0;
    x_op = 2'b10; x_addr = '0; x_wb = '0;
    m_last = 1'b1; m_free = 0; s_e = -1;
  endtask

  task automatic model_step();
    bit w, wr;
    logic [63:0] a, d;
    e++;
    if (!rst_n) begin m_reset(); return; end
    x_ack = '0; x_err = '0; x_op = 2'b10;
    if (e == s_e) begin x_ack[s_p] = 1'b1; x_rd[s_p] = s_rd; end
    if (e >= m_free && (req0 || req1)) begin
      w = (req0 && req1) ? ~m_last : req1;
      m_last = w;
      a  = w ? addr1 : addr0;
      d  = w ? wdata1 : wdata0;
      wr = w ? wr1 : wr0;
      if (a >= 64'd256) begin
        x_ack[w] = 1'b1; x_err[w] = 1'b1; x_rd[w] = '0;
        m_free = e + 2;
      end else begin
        x_op = wr ? 2'b01 : 2'b00; x_addr = a; x_wb = d;
        s_rd = wr ? 64'd0 : ref_mem[a[7:0]];
        if (wr) ref_mem[a[7:0]] = d;
        s_e = e + 1; s_p = w;
        m_free = e + 3;
      end
    end
  endtask

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", n, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("ack0", 64'(ack0), 64'(x_ack[0]));
    chk("ack1", 64'(ack1), 64'(x_ack[1]));
    chk("err0", 64'(err0), 64'(x_err[0]));
    chk("err1", 64'(err1), 64'(x_err[1]));
    chk("rdata0", rdata0, x_rd[0]);
    chk("rdata1", rdata1, x_rd[1]);
    chk("mem_op", 64'(mem_op), 64'(x_op));
    chk("mem_addr", mem_addr, x_addr);
    chk("mem_wb", mem_wb, x_wb);
  endtask

  function automatic logic [63:0] gen_addr();
    int unsigned k = $urandom_range(0, 9);
    if (k <= 6)      return 64'($urandom_range(0, 31));
    else if (k == 7) return 64'hff;
    else if (k == 8) return 64'd256 + 64'($urandom_range(0, 1000));
    else             return {32'h1 + 32'($urandom_range(0, 7)), $urandom};
  endfunction

  task automatic new_req(output logic r, output logic w, output logic [63:0] a, output logic [63:0] d);
    r = 1'b1; w = $urandom_range(0, 1) == 1; a = gen_addr(); d = {$urandom, $urandom};
  endtask

  task automatic drive();
    if (!rand_on) return;
    if (ack_seen0) begin
      if ($urandom_range(0, 3) == 0) req0 = 1'b0; else new_req(req0, wr0, addr0, wdata0);
    end else if (!req0 && $urandom_range(0, 2) == 0) new_req(req0, wr0, addr0, wdata0);
    if (ack_seen1) begin
      if ($urandom_range(0, 3) == 0) req1 = 1'b0; else new_req(req1, wr1, addr1, wdata1);
    end else if (!req1 && $urandom_range(0, 2) == 0) new_req(req1, wr1, addr1, wdata1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1 drive();
    #2 check_all();
    ack_seen0 = ack0; ack_seen1 = ack1;
  endtask

  initial begin
    logic [63:0] v;
    for (int i = 0; i < 256; i++) begin
      v = {$urandom, $urandom}; ram[i] = v; ref_mem[i] = v;
    end
    ram[5] = 64'h1234;  ref_mem[5] = 64'h1234;
    ram[20] = 64'h2020; ref_mem[20] = 64'h2020;
    rst_n = 1'b0; req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    m_reset();

    repeat (2) cycle();
    chk("rst_op", 64'(mem_op), 64'h2);
    chk("rst_ack0", 64'(ack0), 64'h0);
    rst_n = 1'b1;

    // Tie after reset: port 0 first, then port 1.
    req0 = 1; addr0 = 64'd5; req1 = 1; addr1 = 64'd7;
    cycle();
    chk("tie_op", 64'(mem_op), 64'h0);
    chk("tie_addr", mem_addr, 64'd5);
    cycle();
    chk("rd_ack0", 64'(ack0), 64'h1);
    chk("rd_data0", rdata0, 64'h1234);
    chk("rd_ack1", 64'(ack1), 64'h0);
    cycle(); req0 = 0;
    repeat (3) cycle(); req1 = 0;

    // Continuous contention: grants every 3 cycles, alternating.
    req0 = 1; wr0 = 1; addr0 = 64'd10; wdata0 = 64'hAA;
    req1 = 1; wr1 = 0; addr1 = 64'd10;
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("alt_ack0", 64'(ack0), 64'(i % 6 == 1));
      chk("alt_ack1", 64'(ack1), 64'(i % 6 == 4));
      if (i == 4) chk("alt_rdata1", rdata1, 64'hAA);
    end
    req0 = 0; wr0 = 0; req1 = 0;

    // Out-of-range reads.
    req1 = 1; addr1 = 64'd256;
    cycle();
    chk("oor_ack1", 64'(ack1), 64'h1);
    chk("oor_err1", 64'(err1), 64'h1);
    chk("oor_rdata1", rdata1, 64'h0);
    chk("oor_op", 64'(mem_op), 64'h2);
    cycle();
    chk("oor_ack1_end", 64'(ack1), 64'h0);
    addr1 = 64'h1_0000_0005;
    cycle();
    chk("oor2_ack1", 64'(ack1), 64'h1);
    chk("oor2_err1", 64'(err1), 64'h1);
    chk("oor2_op", 64'(mem_op), 64'h2);
    cycle(); req1 = 0;
    cycle();

    // Reset while the read is in ACCESS.
    req0 = 1; wr0 = 0; addr0 = 64'd20;
    cycle();
    rst_n = 1'b0; m_reset();
    #1;
    chk("mid_rst_op", 64'(mem_op), 64'h2);
    chk("mid_rst_addr", mem_addr, 64'h0);
    chk("mid_rst_ack0", 64'(ack0), 64'h0);
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    cycle();
    chk("reissue_ack0", 64'(ack0), 64'h1);
    chk("reissue_data0", rdata0, 64'h2020);
    cycle(); req0 = 0;
    cycle();

    // Console write.
    req0 = 1; wr0 = 1; addr0 = 64'hff; wdata0 = 64'h42;
    cycle();
    chk("con_op", 64'(mem_op), 64'h1);
    chk("con_addr", mem_addr, 64'hff);
    chk("con_wb", mem_wb, 64'h42);
    cycle();
    chk("con_ack0", 64'(ack0), 64'h1);
    cycle(); req0 = 0; wr0 = 0;
    cycle();
    chk("con_op_nop", 64'(mem_op), 64'h2);

    // Random traffic against the model.
    ack_seen0 = 0; ack_seen1 = 0;
    rand_on = 1;
    repeat (3000) cycle();
    rand_on = 0; req0 = 0; req1 = 0;
    repeat (6) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-ported `ram` word memory between two requesters: port 0 is the subleq core, port 1 is the loader/debug port. Requests are granted round-robin and issued to the RAM one at a time. Read data is returned with a one-cycle `ack`. Addresses outside the memory are rejected with an error response and never reach the RAM.

## Interface
- `ADDR_W`, 64: address width on all ports.
- `DATA_W`, 64: data width on all ports.
- `MEM_WORDS`, 256: number of RAM words; valid addresses are 0..MEM_WORDS-1.
- `clk`  in  1  single clock; RAM executes on the negedge of the same clock.
- `reset`  in  1  asynchronous, active-low (0 = in reset).
- `req0` / `req1`  in  1  access request, level.
- `wr0` / `wr1`  in  1  0 = read, 1 = write.
- `addr0` / `addr1`  in  ADDR_W  word address.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `ack0` / `ack1`  out  1  one-cycle completion pulse.
- `rdata0` / `rdata1`  out  DATA_W  read data; valid while `ack` is high.
- `err0` / `err1`  out  1  address out of range; valid while `ack` is high.
- `mem_op`  out  2  to RAM: 00 = read, 01 = write, 10 = NOP.
- `mem_addr`  out  ADDR_W  to RAM.
- `mem_write_bytes`  out  DATA_W  to RAM.
- `mem_data`  in  DATA_W  from RAM; updated on the negedge.

## Operation
- FSM states:
  - IDLE: no access in flight.
  - ACCESS: RAM command driven.
  - RESP: `ack` high to the owner.
- IDLE, at least one `req` high at a posedge:
  - Pick the owner.
  - If owner `addr >= MEM_WORDS`: set `err`, `rdata = 0`, `ack = 1`; `mem_op` stays NOP; go to RESP.
  - Otherwise: register `mem_op` (RD/WR), `mem_addr`, `mem_write_bytes` from the owner; go to ACCESS.
- ACCESS: at the next posedge:
  - Capture `mem_data` into the owner's `rdata`; for writes, `rdata` is don't-care and is driven 0.
  - `mem_op <= NOP`; owner `ack <= 1`, `err <= 0`; go to RESP.
- RESP: at the next posedge, `ack <= 0`, `err <= 0`; go to IDLE. Requests are not sampled in RESP.
- Arbitration is round-robin on `last_grant`, which updates on every grant (including error responses).
  - If both ports request, the port that is not `last_grant` wins.
  - If one port requests, it wins.
- Requester rules:
  - Hold `req`, `wr`, `addr` and `wdata` stable until `ack` is sampled high.
  - At that edge, drop `req` or present the next request; it is sampled in IDLE one cycle later.
- Writes to address 0xff are passed through unchanged; the RAM treats 0xff as the console.
- The non-owner's `ack`, `err` and `rdata` are untouched during a transaction. The arbiter never asserts both `ack`s at once.
- Reset (async, active-low) clears the following immediately, regardless of state:
  - `state = IDLE`, `mem_op = NOP`, `mem_addr = 0`, `mem_write_bytes = 0`.
  - All `ack` and `err` = 0, all `rdata` = 0.
  - `last_grant = 1`, so port 0 wins the first tie.
- Reset during ACCESS or RESP: the `ack` is lost. A write already issued may or may not have landed; requesters must reissue after reset.

## Timing
- Valid access: `req` sampled at edge T0 → `mem_op` valid after T0 → RAM executes at negedge T0+½ → `ack` high from T1 to T2.
- Out-of-range access: `ack` and `err` high from T0 to T1.
- Throughput: one access per 3 cycles (IDLE, ACCESS, RESP). Back-to-back requests from the same port are granted at T0 + 3.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Width rule: the range check compares the full ADDR_W address against MEM_WORDS. High bits are never truncated, so `0x100` and `0x1_0000_0005` are errors, not aliases.

## Structure
- Package `mem_pkg`:
  - `MEM_RD = 2'b00`, `MEM_WR = 2'b01`, `MEM_NOP = 2'b10`.
  - `CONSOLE_ADDR = 8'hff`.
  - FSM state typedef {IDLE, ACCESS, RESP}.
- Sub-module `rr_pick2`: combinational 2-way round-robin selector (inputs `req0`, `req1`, `last_grant`; outputs `grant_valid`, `grant_id`). FSM and datapath stay in `mem_arbiter`.
- Top level drives the RAM's active-high reset from `~reset`.

## Test plan
- Reset:
  - Drive `reset = 0` mid-cycle → all outputs return immediately to their reset values, `mem_op = 10`.
  - Release, then assert `req0` and `req1` at the same edge → port 0 is granted first.
- Read: memory[5] = 0x1234; `req0` read, addr 5 at T0 → `mem_op = 00` and `mem_addr = 5` after T0; `ack0 = 1`, `rdata0 = 0x1234`, `err0 = 0` from T1 to T2; `ack1` stays 0.
- Arbitration:
  - Both ports request continuously; port 0 writes 0xAA to 10, port 1 reads 10.
  - Grants alternate 0, 1, 0, …; port 1's read returns 0xAA.
  - Each grant is exactly 3 cycles apart.
- Range error: `req1` read, addr 256 → `ack1 = 1`, `err1 = 1`, `rdata1 = 0` one cycle after sampling; `mem_op` stays 10. Repeat with addr 0x1_0000_0005 → same result.
- Reset mid-transaction: assert `reset = 0` while in ACCESS → `ack0` never pulses, `mem_op = 10` immediately; after release, the reissued read returns correct data.
- Console: `req0` write 0x42 to 0xff → `mem_op = 01`, `mem_addr = 0xff`, `mem_write_bytes = 0x42` for one cycle; RAM prints "console 42"; `ack0` pulses normally.
